// File: rtl/timer_cmp_pkg.sv
// Shared register map, CTRL bit positions and FSM state type for the machine-timer compare stage.
package timer_cmp_pkg;

  localparam logic [2:0] REG_CMP_LO   = 3'd0;
  localparam logic [2:0] REG_CMP_HI   = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_PERIOD   = 3'd3;
  localparam logic [2:0] REG_MTIME_LO = 3'd4;
  localparam logic [2:0] REG_MTIME_HI = 3'd5;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_PEND     = 2;

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} tcmp_state_e;

endpackage

// File: rtl/timer_cmp_irq.sv
// Machine-timer compare with latched interrupt and 32-bit register port.
// TIMER_CMP_PERIODIC_EN enables the PERIOD register and CTRL.PERIODIC auto-reload.
// state | meaning
// IDLE  | EN=0, pending held, no compare
// ARMED | comparing mtime >= cmp every cycle
// FIRED | one-shot fired, waits for a CMP_* write to re-arm
module timer_cmp_irq
  import timer_cmp_pkg::*;
#(
  parameter int               CNT_W    = 64,
  parameter int               PERIOD_W = 32,
  parameter logic [CNT_W-1:0] CMP_RST  = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] mtime_i,
  input  logic             wr_en_i,
  input  logic [2:0]       wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [2:0]       rd_addr_i,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic             timer_irq_o
);

  localparam int HI_W = CNT_W - 32;

  tcmp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cmp_q, cmp_d, cmp_reload;
  logic [HI_W-1:0]  snap_q, snap_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             en_q, en_d, pend_q, pend_d, irq_q, irq_d;
  logic             hit, wr_ctrl, wr_cmp_lo, wr_cmp_hi;

`ifdef TIMER_CMP_PERIODIC_EN
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                periodic_q, periodic_d;
  assign cmp_reload = cmp_q + CNT_W'(period_q);
`else
  logic [PERIOD_W-1:0] period_q;
  logic                periodic_q;
  assign period_q   = '0;
  assign periodic_q = 1'b0;
  assign cmp_reload = cmp_q;
`endif

  assign hit       = (mtime_i >= cmp_q);
  assign wr_ctrl   = wr_en_i && (wr_addr_i == REG_CTRL);
  assign wr_cmp_lo = wr_en_i && (wr_addr_i == REG_CMP_LO);
  assign wr_cmp_hi = wr_en_i && (wr_addr_i == REG_CMP_HI);

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
`ifdef TIMER_CMP_PERIODIC_EN
    period_d   = period_q;
    periodic_d = periodic_q;
    if (wr_en_i && (wr_addr_i == REG_PERIOD)) period_d = wr_data_i[PERIOD_W-1:0];
    if (wr_ctrl) periodic_d = wr_data_i[CTRL_PERIODIC];
`endif
    if (wr_ctrl) begin
      en_d = wr_data_i[CTRL_EN];
      if (wr_data_i[CTRL_PEND]) pend_d = 1'b0;
    end

    case (state_q)
      IDLE:  if (wr_ctrl && wr_data_i[CTRL_EN]) state_d = ARMED;
      ARMED: if (hit) begin
        pend_d = 1'b1;
        if (periodic_q) cmp_d = cmp_reload;
        else if (!(wr_cmp_lo || wr_cmp_hi)) state_d = FIRED;
      end
      FIRED: if (wr_cmp_lo || wr_cmp_hi) state_d = ARMED;
      default: state_d = IDLE;
    endcase

    // a software compare write overrides any same-cycle reload
    if (wr_cmp_lo) cmp_d = {cmp_q[CNT_W-1:32], wr_data_i};
    if (wr_cmp_hi) cmp_d = {wr_data_i[HI_W-1:0], cmp_q[31:0]};
    if (wr_ctrl && !wr_data_i[CTRL_EN]) state_d = IDLE;

    irq_d = pend_d & en_d;

    rd_valid_d = rd_en_i;
    rd_data_d  = '0;
    if (rd_en_i) begin
      case (rd_addr_i)
        REG_CMP_LO: rd_data_d = cmp_q[31:0];
        REG_CMP_HI: rd_data_d = 32'(cmp_q[CNT_W-1:32]);
        REG_CTRL: begin
          rd_data_d[CTRL_EN]       = en_q;
          rd_data_d[CTRL_PERIODIC] = periodic_q;
          rd_data_d[CTRL_PEND]     = pend_q;
        end
        REG_PERIOD:   rd_data_d = 32'(period_q);
        REG_MTIME_LO: begin
          rd_data_d = mtime_i[31:0];
          snap_d    = mtime_i[CNT_W-1:32];
        end
        REG_MTIME_HI: rd_data_d = 32'(snap_q);
        default:      rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmp_q      <= CMP_RST;
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
      irq_q      <= 1'b0;
      snap_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef TIMER_CMP_PERIODIC_EN
      period_q   <= '0;
      periodic_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
      snap_q     <= snap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef TIMER_CMP_PERIODIC_EN
      period_q   <= period_d;
      periodic_q <= periodic_d;
`endif
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed bench for timer_cmp_irq: register reads and interrupt fire times go through a scoreboard queue.
module tb_timer_cmp_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] mtime = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  timer_cmp_irq dut (
    .clk(clk), .rst_n(rst_n), .mtime_i(mtime),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .timer_irq_o(irq)
  );

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [63:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    logic [63:0] e;
    string       tag;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_output observed=%0h expected=none", obs);
    end
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [63:0] e, input string tag);
    rd_en = 1'b1; rd_addr = a;
    push(e, tag);
    step();
    rd_en = 1'b0;
    chk({tag, "_valid"}, {63'd0, rd_valid}, 64'd1);
    pop_check({32'd0, rd_data});
  endtask

  initial begin
    int  first_fire;
    bit  clr;

    // reset state
    #23;
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    rd(3'd0, 64'hFFFF_FFFF, "rst_cmp_lo");
    rd(3'd1, 64'hFFFF_FFFF, "rst_cmp_hi");
    rd(3'd2, 64'h0, "rst_ctrl");
    rd(3'd3, 64'h0, "rst_period");
    step();
    chk("idle_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("idle_rd_data", {32'd0, rd_data}, 64'd0);

    // read and write of the same register in one cycle returns the old value
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h1234;
    rd_en = 1'b1; rd_addr = 3'd0;
    push(64'hFFFF_FFFF, "rw_same_cycle");
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    pop_check({32'd0, rd_data});
    rd(3'd0, 64'h1234, "rw_after");

    // snapshot of the upper time half
    mtime = 64'h1_FFFF_FFFF;
    rd(3'd4, 64'hFFFF_FFFF, "mtime_lo");
    mtime = 64'h2_0000_0000;
    rd(3'd5, 64'h1, "mtime_hi_snap");
    wr(3'd5, 32'hABC);
    rd(3'd5, 64'h1, "ro_write_ignored");
    wr(3'd6, 32'h55);
    rd(3'd6, 64'h0, "reg6_zero");

`ifdef TIMER_CMP_PERIODIC_EN
    // periodic: fires at 50, 70, 90
    mtime = 64'd0;
    wr(3'd0, 32'd50);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd20);
    wr(3'd2, 32'h3);
    rd(3'd3, 64'd20, "period_rd");
    rd(3'd2, 64'h3, "ctrl_periodic_rd");
    push(64'd50, "periodic_fire0");
    push(64'd70, "periodic_fire1");
    push(64'd90, "periodic_fire2");
    clr = 1'b0;
    for (int t = 0; t <= 95; t++) begin
      mtime = 64'(t);
      if (clr) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h7; end
      step();
      wr_en = 1'b0;
      clr = 1'b0;
      if (irq === 1'b1) begin
        pop_check(64'(t));
        clr = 1'b1;
      end
    end
    chk("periodic_missing", 64'(exp_q.size()), 64'd0);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
    rd(3'd0, 64'd110, "periodic_cmp");

    // wrap of the reload adder
    wr(3'd2, 32'h4);
    mtime = 64'hFFFF_FFFF_FFFF_FFFA;
    wr(3'd0, 32'hFFFF_FFFB);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd3, 32'd10);
    wr(3'd2, 32'h7);
    chk("wrap_pre_irq", {63'd0, irq}, 64'd0);
    mtime = 64'hFFFF_FFFF_FFFF_FFFB;
    step();
    chk("wrap_fire", {63'd0, irq}, 64'd1);
    rd(3'd0, 64'd5, "wrap_cmp");
    rd(3'd0, 64'd15, "wrap_immediate_refire");
    wr(3'd2, 32'h4);
    wr(3'd2, 32'h4);
    chk("wrap_disabled_irq", {63'd0, irq}, 64'd0);
`else
    wr(3'd3, 32'd7);
    rd(3'd3, 64'd0, "period_off");
    wr(3'd2, 32'h3);
    rd(3'd2, 64'h1, "ctrl_periodic_off");
`endif

    // one-shot
    mtime = 64'd0;
    wr(3'd0, 32'd100);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'h5);
    push(64'd100, "oneshot_fire");
    first_fire = -1;
    for (int t = 0; t <= 102; t++) begin
      mtime = 64'(t);
      step();
      if (irq === 1'b1 && first_fire < 0) begin
        first_fire = t;
        pop_check(64'(t));
      end
    end
    if (first_fire < 0) pop_check(64'hDEAD);
    chk("oneshot_hold", {63'd0, irq}, 64'd1);

    // collision: hit and W1C PEND in the same cycle
    wr(3'd0, 32'd105);
    chk("rearm_irq_held", {63'd0, irq}, 64'd1);
    mtime = 64'd105;
    wr(3'd2, 32'h5);
    chk("collision_irq", {63'd0, irq}, 64'd1);
    rd(3'd2, 64'h5, "collision_ctrl");
    wr(3'd2, 32'h5);
    chk("w1c_irq", {63'd0, irq}, 64'd0);
    for (int t = 106; t <= 108; t++) begin
      mtime = 64'(t);
      step();
    end
    chk("no_refire", {63'd0, irq}, 64'd0);
    rd(3'd2, 64'h1, "ctrl_after_w1c");
    rd(3'd0, 64'd105, "oneshot_cmp_kept");

    // reset while FIRED
    wr(3'd0, 32'd110);
    mtime = 64'd110;
    step();
    chk("refire_irq", {63'd0, irq}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {63'd0, irq}, 64'd0);
    step();
    rst_n = 1'b1;
    mtime = 64'd0;
    rd(3'd0, 64'hFFFF_FFFF, "post_rst_cmp_lo");
    rd(3'd1, 64'hFFFF_FFFF, "post_rst_cmp_hi");
    rd(3'd2, 64'h0, "post_rst_ctrl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
